writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-side master for the register file's single write port (writeReg, writeData, regWrite, float).
- Collects completed results from three producers: 0 = integer ALU, 1 = FP unit, 2 = load/memory stage.
- Buffers one result per producer and grants one result per cycle using round-robin.
- Drives registered write controls so that at most one register write reaches the file per clock.

Parameters:
- NSRC, 3, number of producers; this spec is fixed at 3.
- IDXW, 6, register index width; matches the register file write index.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered and in-flight results.
- srcValid  in  3  bit i: producer i presents a result.
- srcReady  out  3  bit i: arbiter accepts producer i this cycle.
- srcReg  in  3*IDXW  destination index per producer; slice i = bits [i*IDXW +: IDXW].
- srcData  in  3*DW  result data per producer; slice i = bits [i*DW +: DW].
- srcFloat  in  3  bit i: 1 = target is the FP bank, 0 = target is the integer bank.
- regWrite  out  1  write enable to the register file.
- float  out  1  bank select to the register file.
- writeReg  out  IDXW  write index.
- writeData  out  DW  write data.
- pending  out  2  count of occupied buffers, 0..3.
- idle  out  1  high when pending==0 and regWrite==0.

Behaviour:
- Reset values: all buffers empty; rrPtr=2, so producer 0 has first priority; regWrite=0, float=0, writeReg=0, writeData=0; pending=0; idle=1.
- Per-producer buffer:
  - One entry per producer, with fields valid, reg, data, float.
  - Accept at posedge when srcValid[i] & srcReady[i].
- srcReady[i] = !flush & !reset & (!bufValid[i] | grant[i]).
  - Same-cycle refill of a buffer being granted is allowed, so one producer can sustain 1 result/cycle when uncontested.
- Grant (combinational, from buffer state only):
  - Search starts at (rrPtr+1) mod 3 and picks the first valid buffer.
  - At most one grant per cycle. A new input is never granted in the cycle it is accepted.
  - rrPtr updates to the granted index on the posedge where the grant happens; it is unchanged when nothing is granted.
- Output register, loaded every posedge:
  - regWrite = grant exists & !dropZero.
  - writeReg, writeData, float take the granted buffer's fields.
  - If there is no grant: regWrite=0, other outputs hold their last values.
- Integer $zero protection:
  - dropZero = granted float==0 & reg==0.
  - The entry is consumed and its buffer freed, but regWrite stays 0.
  - FP index 0 is written normally.
- Latency: accept at edge E, then regWrite high from E+1 to E+2 if uncontested, and the register file commits at E+2.
  - Under contention, each extra producer ahead in rotation adds 1 cycle.
  - Worst case 3 cycles from accept to output load.
- pending counts occupied buffers after each edge:
  - +1 for each accept.
  - -1 for the grant.
  - A simultaneous accept and grant on the same producer leaves that producer's contribution unchanged.
  - pending never exceeds 3.
- Indices 32..63: passed through unmodified; the register file address space is the producer's responsibility.
- flush, at posedge:
  - All buffers are cleared and regWrite is set to 0.
  - No accepts or grants occur that cycle, and rrPtr holds.
  - Data and index outputs hold.
- reset mid-operation: same as the reset state at the next edge; in-flight results are lost. reset dominates flush.
- No combinational path from srcValid to any output except srcReady (srcReady does not depend on srcValid).

Test Plan:
- Single ALU write: src0 valid, reg=5, data=0xDEADBEEF, float=0, at edge 1 -> regWrite=1, writeReg=5, writeData=0xDEADBEEF, float=0 during cycle 2 only; pending 1 then 0; idle returns to 1.
- Three-way contention: all three producers valid at one edge, with regs 1, 2, 3 -> outputs appear in order src0, src1, src2 on three consecutive cycles. Then refill src0 and src2 together -> src0 next (rrPtr=2), then src2.
- Streaming: src1 valid every cycle for 8 cycles with an incrementing float-bank index -> srcReady[1] stays 1 and 8 back-to-back regWrite=1 cycles with float=1. Adding src0 mid-stream -> strict alternation, and srcReady[1] drops on cycles where src1's buffer is not granted.
- Zero register: src2 int reg=0, data=0x1234 -> buffer freed, regWrite stays 0, pending returns to 0. FP reg=0 -> regWrite=1 with float=1.
- Flush: all three buffers full, assert flush for 1 cycle -> next cycle pending=0, regWrite=0, srcReady=0 during the flush cycle, and no writes afterwards.
- Reset with 2 entries pending -> after the edge, all outputs are at reset values and the next grant goes to src0 first.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Producer-side result handshake and register-file write bus for the writeback arbiter.
// master = arbiter side, slave = producers plus register file.
interface writeback_arbiter_if #(
   parameter int unsigned NSRC = 3,
   parameter int unsigned IDXW = 6,
   parameter int unsigned DW   = 32
);
   logic [NSRC-1:0]      srcValid;
   logic [NSRC-1:0]      srcReady;
   logic [NSRC*IDXW-1:0] srcReg;
   logic [NSRC*DW-1:0]   srcData;
   logic [NSRC-1:0]      srcFloat;
   logic                 regWrite;
   logic                 float;
   logic [IDXW-1:0]      writeReg;
   logic [DW-1:0]        writeData;

   modport master (
      input  srcValid, srcReg, srcData, srcFloat,
      output srcReady, regWrite, float, writeReg, writeData
   );

   modport slave (
      output srcValid, srcReg, srcData, srcFloat,
      input  srcReady, regWrite, float, writeReg, writeData
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter buffering one result per producer and driving one registered
// register-file write per clock.
module writeback_arbiter #(
   parameter int unsigned NSRC = 3,
   parameter int unsigned IDXW = 6,
   parameter int unsigned DW   = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   writeback_arbiter_if.master wb,
   output logic [1:0]          pending,
   output logic                idle
);

   logic [NSRC-1:0] buf_valid_q, buf_valid_d;
   logic [IDXW-1:0] buf_reg_q   [NSRC];
   logic [IDXW-1:0] buf_reg_d   [NSRC];
   logic [DW-1:0]   buf_data_q  [NSRC];
   logic [DW-1:0]   buf_data_d  [NSRC];
   logic [NSRC-1:0] buf_float_q, buf_float_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic            reg_write_q, reg_write_d;
   logic            float_q, float_d;
   logic [IDXW-1:0] write_reg_q, write_reg_d;
   logic [DW-1:0]   write_data_q, write_data_d;

   logic [NSRC-1:0] grant;
   logic [1:0]      grant_idx;
   logic            grant_any;
   logic            drop_zero;
   logic [NSRC-1:0] accept;

   // Rotating priority: first valid buffer after the last granted one.
   always_comb begin
      int unsigned cand;
      grant     = '0;
      grant_idx = 2'd0;
      grant_any = 1'b0;
      for (int unsigned k = 1; k <= NSRC; k++) begin
         cand = (32'(rr_ptr_q) + k) % NSRC;
         if (!grant_any && buf_valid_q[cand]) begin
            grant_any   = 1'b1;
            grant_idx   = 2'(cand);
            grant[cand] = 1'b1;
         end
      end
   end

   assign drop_zero   = !buf_float_q[grant_idx] && (buf_reg_q[grant_idx] == '0);
   assign wb.srcReady = {NSRC{!flush && !reset}} & (~buf_valid_q | grant);
   assign accept      = wb.srcValid & wb.srcReady;

   always_comb begin
      buf_valid_d  = buf_valid_q;
      buf_reg_d    = buf_reg_q;
      buf_data_d   = buf_data_q;
      buf_float_d  = buf_float_q;
      rr_ptr_d     = rr_ptr_q;
      reg_write_d  = 1'b0;
      float_d      = float_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (flush) begin
         buf_valid_d = '0;
      end else begin
         if (grant_any) begin
            buf_valid_d[grant_idx] = 1'b0;
            rr_ptr_d               = grant_idx;
            reg_write_d            = !drop_zero;
            float_d                = buf_float_q[grant_idx];
            write_reg_d            = buf_reg_q[grant_idx];
            write_data_d           = buf_data_q[grant_idx];
         end
         // Accept after grant so a granted buffer can be refilled in the same cycle.
         for (int unsigned i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
               buf_valid_d[i] = 1'b1;
               buf_reg_d[i]   = wb.srcReg[i*IDXW +: IDXW];
               buf_data_d[i]  = wb.srcData[i*DW +: DW];
               buf_float_d[i] = wb.srcFloat[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid_q  <= '0;
         rr_ptr_q     <= 2'd2;
         reg_write_q  <= 1'b0;
         float_q      <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         buf_valid_q  <= buf_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         reg_write_q  <= reg_write_d;
         float_q      <= float_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Payload is qualified by buf_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      buf_reg_q   <= buf_reg_d;
      buf_data_q  <= buf_data_d;
      buf_float_q <= buf_float_d;
   end

   assign wb.regWrite  = reg_write_q;
   assign wb.float     = float_q;
   assign wb.writeReg  = write_reg_q;
   assign wb.writeData = write_data_q;

   assign pending = {1'b0, buf_valid_q[0]} + {1'b0, buf_valid_q[1]} + {1'b0, buf_valid_q[2]};
   assign idle    = (pending == 2'd0) && !reg_write_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter, checked every cycle against a
// behavioural model of buffers, rotation pointer and output register.
module tb_writeback_arbiter;
   localparam int unsigned IDXW = 6;
   localparam int unsigned DW   = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [1:0] pending;
   logic       idle;
   int         n_vec = 0;
   int         n_err = 0;

   writeback_arbiter_if #(.NSRC(3), .IDXW(IDXW), .DW(DW)) wb_if ();

   writeback_arbiter #(.NSRC(3), .IDXW(IDXW), .DW(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wb      (wb_if),
      .pending (pending),
      .idle    (idle)
   );

   always #5 clk = ~clk;

   // Model state
   bit          m_valid [3];
   int unsigned m_reg   [3];
   int unsigned m_data  [3];
   bit          m_float [3];
   int          m_rr;
   bit          m_rw;
   bit          m_fl;
   int unsigned m_wr;
   int unsigned m_wd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int m_grant();
      for (int k = 1; k <= 3; k++) begin
         if (m_valid[(m_rr + k) % 3]) return (m_rr + k) % 3;
      end
      return -1;
   endfunction

   function automatic logic [2:0] m_ready();
      logic [2:0] r;
      int g;
      g = m_grant();
      for (int i = 0; i < 3; i++) r[i] = !reset && !flush && (!m_valid[i] || g == i);
      return r;
   endfunction

   function automatic int m_pending();
      return int'(m_valid[0]) + int'(m_valid[1]) + int'(m_valid[2]);
   endfunction

   task automatic model_step();
      int g;
      logic [2:0] rdy;
      rdy = m_ready();
      g   = m_grant();
      if (reset) begin
         for (int i = 0; i < 3; i++) m_valid[i] = 0;
         m_rr = 2; m_rw = 0; m_fl = 0; m_wr = 0; m_wd = 0;
      end else if (flush) begin
         for (int i = 0; i < 3; i++) m_valid[i] = 0;
         m_rw = 0;
      end else begin
         m_rw = 0;
         if (g >= 0) begin
            m_rw = m_float[g] || m_reg[g] != 0;
            m_fl = m_float[g];
            m_wr = m_reg[g];
            m_wd = m_data[g];
            m_valid[g] = 0;
            m_rr = g;
         end
         for (int i = 0; i < 3; i++) begin
            if (wb_if.srcValid[i] && rdy[i]) begin
               m_valid[i] = 1;
               m_reg[i]   = wb_if.srcReg[i*IDXW +: IDXW];
               m_data[i]  = wb_if.srcData[i*DW +: DW];
               m_float[i] = wb_if.srcFloat[i];
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("srcReady", 64'(wb_if.srcReady), 64'(m_ready()));
      chk("regWrite", 64'(wb_if.regWrite), 64'(m_rw));
      chk("float", 64'(wb_if.float), 64'(m_fl));
      chk("writeReg", 64'(wb_if.writeReg), 64'(m_wr));
      chk("writeData", 64'(wb_if.writeData), 64'(m_wd));
      chk("pending", 64'(pending), 64'(m_pending()));
      chk("idle", 64'(idle), 64'(m_pending() == 0 && !m_rw));
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_src(input int i, input int unsigned r, input int unsigned d, input bit f);
      wb_if.srcReg[i*IDXW +: IDXW] = IDXW'(r);
      wb_if.srcData[i*DW +: DW]    = d;
      wb_if.srcFloat[i]            = f;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wb_if.srcValid = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      wb_if.srcValid = '0;
      wb_if.srcReg   = '0;
      wb_if.srcData  = '0;
      wb_if.srcFloat = '0;
      m_rr = 2; m_rw = 0; m_fl = 0; m_wr = 0; m_wd = 0;
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 0; m_reg[i] = 0; m_data[i] = 0; m_float[i] = 0;
      end
      do_reset();
      chk("reset_regWrite", 64'(wb_if.regWrite), 64'd0);
      chk("reset_pending", 64'(pending), 64'd0);
      chk("reset_idle", 64'(idle), 64'd1);
      chk("reset_writeReg", 64'(wb_if.writeReg), 64'd0);

      // Single ALU write
      set_src(0, 5, 32'hDEADBEEF, 0);
      wb_if.srcValid = 3'b001;
      tick();
      wb_if.srcValid = '0;
      chk("alu_pending1", 64'(pending), 64'd1);
      chk("alu_rw0", 64'(wb_if.regWrite), 64'd0);
      tick();
      chk("alu_rw1", 64'(wb_if.regWrite), 64'd1);
      chk("alu_reg", 64'(wb_if.writeReg), 64'd5);
      chk("alu_data", 64'(wb_if.writeData), 64'hDEADBEEF);
      chk("alu_float", 64'(wb_if.float), 64'd0);
      chk("alu_pending0", 64'(pending), 64'd0);
      tick();
      chk("alu_rw_off", 64'(wb_if.regWrite), 64'd0);
      chk("alu_idle", 64'(idle), 64'd1);

      // Three-way contention from reset priority
      do_reset();
      for (int i = 0; i < 3; i++) set_src(i, i + 1, 32'h100 + i, 0);
      wb_if.srcValid = 3'b111;
      tick();
      wb_if.srcValid = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rr_order", 64'(wb_if.writeReg), 64'(i + 1));
      end
      set_src(0, 10, 32'hA, 0);
      set_src(2, 12, 32'hC, 0);
      wb_if.srcValid = 3'b101;
      tick();
      wb_if.srcValid = '0;
      tick();
      chk("refill_first", 64'(wb_if.writeReg), 64'd10);
      tick();
      chk("refill_second", 64'(wb_if.writeReg), 64'd12);

      // Streaming src1 with a mid-stream src0
      for (int c = 0; c < 12; c++) begin
         set_src(1, 32 + c, 32'hF000 + c, 1);
         set_src(0, 7, 32'h7700 + c, 0);
         wb_if.srcValid = (c >= 8) ? 3'b011 : 3'b010;
         #1;
         if (c < 8) chk("stream_ready", 64'(wb_if.srcReady[1]), 64'd1);
         tick();
      end
      wb_if.srcValid = '0;
      repeat (4) tick();

      // Zero register protection
      set_src(2, 0, 32'h1234, 0);
      wb_if.srcValid = 3'b100;
      tick();
      wb_if.srcValid = '0;
      tick();
      chk("zero_rw", 64'(wb_if.regWrite), 64'd0);
      chk("zero_pending", 64'(pending), 64'd0);
      set_src(2, 0, 32'h5678, 1);
      wb_if.srcValid = 3'b100;
      tick();
      wb_if.srcValid = '0;
      tick();
      chk("fp_zero_rw", 64'(wb_if.regWrite), 64'd1);
      chk("fp_zero_float", 64'(wb_if.float), 64'd1);

      // Flush with all buffers full
      for (int i = 0; i < 3; i++) set_src(i, 20 + i, 32'h2000 + i, 0);
      wb_if.srcValid = 3'b111;
      tick();
      wb_if.srcValid = '0;
      flush = 1'b1;
      #1;
      chk("flush_ready", 64'(wb_if.srcReady), 64'd0);
      tick();
      flush = 1'b0;
      chk("flush_pending", 64'(pending), 64'd0);
      chk("flush_rw", 64'(wb_if.regWrite), 64'd0);
      tick();
      chk("flush_no_write", 64'(wb_if.regWrite), 64'd0);

      // Reset with two entries pending, then src0 wins first
      set_src(1, 41, 32'h41, 0);
      set_src(2, 42, 32'h42, 0);
      wb_if.srcValid = 3'b110;
      tick();
      wb_if.srcValid = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_pending", 64'(pending), 64'd0);
      chk("rst_mid_rw", 64'(wb_if.regWrite), 64'd0);
      chk("rst_mid_data", 64'(wb_if.writeData), 64'd0);
      for (int i = 0; i < 3; i++) set_src(i, 50 + i, 32'h50 + i, 0);
      wb_if.srcValid = 3'b111;
      tick();
      wb_if.srcValid = '0;
      tick();
      chk("rst_mid_first", 64'(wb_if.writeReg), 64'd50);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) begin
            set_src(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 63), $urandom,
                    1'($urandom_range(0, 1)));
         end
         wb_if.srcValid = 3'($urandom);
         flush = ($urandom_range(0, 24) == 0);
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      flush = 1'b0;
      wb_if.srcValid = '0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
